// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of byte-masked stores feeding the shared DMEM/IMEM write port,
// with per-byte store-to-load forwarding of pending DMEM stores.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [AWIDTH-1:0]          st_addr_i,
  input  logic [31:0]                st_data_i,
  input  logic [3:0]                 st_dmem_wea_i,
  input  logic [3:0]                 st_imem_wea_i,
  output logic                       mem_valid_o,
  input  logic                       mem_ready_i,
  output logic [AWIDTH-1:0]          mem_addr_o,
  output logic [31:0]                mem_din_o,
  output logic [3:0]                 mem_dmem_wea_o,
  output logic [3:0]                 mem_imem_wea_o,
  input  logic [AWIDTH-1:0]          ld_addr_i,
  output logic [3:0]                 fwd_mask_o,
  output logic [31:0]                fwd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  vld_q;
  logic [AWIDTH-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [3:0]        dwe_q  [DEPTH];
  logic [3:0]        iwe_q  [DEPTH];
  logic [PW-1:0]     wr_q, rd_q, hd, fj;
  logic [CW-1:0]     count_q, count_d;
  logic              enq, deq;

  assign st_ready_o     = count_q != CW'(DEPTH);
  assign enq            = st_valid_i && st_ready_o && (|st_dmem_wea_i || |st_imem_wea_i);
  assign deq            = mem_valid_o && mem_ready_i;
  assign count_d        = count_q + CW'(enq) - CW'(deq);
  assign count_o        = count_q;
  assign empty_o        = count_q == '0;
  // When drained, the slot just behind rd_q still holds the last store presented.
  assign hd             = empty_o ? rd_q - PW'(1) : rd_q;
  assign mem_valid_o    = vld_q[rd_q];
  assign mem_addr_o     = addr_q[hd];
  assign mem_din_o      = data_q[hd];
  assign mem_dmem_wea_o = mem_valid_o ? dwe_q[rd_q] : 4'h0;
  assign mem_imem_wea_o = mem_valid_o ? iwe_q[rd_q] : 4'h0;

  // Walk oldest to youngest so the youngest hitting store wins each lane.
  always_comb begin
    fwd_mask_o = '0;
    fwd_data_o = '0;
    fj = rd_q;
    for (int k = 0; k < DEPTH; k++) begin
      fj = rd_q + PW'(k);
      for (int l = 0; l < 4; l++)
        if (vld_q[fj] && dwe_q[fj][l] && addr_q[fj][AWIDTH-1:2] == ld_addr_i[AWIDTH-1:2]) begin
          fwd_mask_o[l] = 1'b1;
          fwd_data_o[8*l +: 8] = data_q[fj][8*l +: 8];
        end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        dwe_q[i]  <= '0;
        iwe_q[i]  <= '0;
      end
    end else begin
      if (enq) begin
        vld_q[wr_q]  <= 1'b1;
        addr_q[wr_q] <= st_addr_i;
        data_q[wr_q] <= st_data_i;
        dwe_q[wr_q]  <= st_dmem_wea_i;
        iwe_q[wr_q]  <= st_imem_wea_i;
        wr_q         <= wr_q + PW'(1);
      end
      if (deq) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= rd_q + PW'(1);
      end
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vector table, async reset sequence and randomized run against a queue model.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 0, rst_n = 0;
  logic        st_valid_i = 0, mem_ready_i = 0;
  logic [31:0] st_addr_i = 0, st_data_i = 0, ld_addr_i = 0;
  logic [3:0]  st_dmem_wea_i = 0, st_imem_wea_i = 0;
  logic        st_ready_o, mem_valid_o, empty_o;
  logic [31:0] mem_addr_o, mem_din_o, fwd_data_o;
  logic [3:0]  mem_dmem_wea_o, mem_imem_wea_o, fwd_mask_o;
  logic [2:0]  count_o;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AWIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
    .st_dmem_wea_i(st_dmem_wea_i), .st_imem_wea_i(st_imem_wea_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
    .mem_dmem_wea_o(mem_dmem_wea_o), .mem_imem_wea_o(mem_imem_wea_o),
    .ld_addr_i(ld_addr_i), .fwd_mask_o(fwd_mask_o), .fwd_data_o(fwd_data_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic sv; logic [31:0] a, d; logic [3:0] dw, iw; logic mr; logic [31:0] ld;
    logic e_rdy, e_mv; logic [31:0] e_ma, e_md; logic [3:0] e_mdw, e_miw; int e_cnt;
    logic [3:0] e_fm; logic [31:0] e_fd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(logic sv, logic [31:0] a, d, logic [3:0] dw, iw, logic mr, logic [31:0] ld,
                             logic rdy, mv, logic [31:0] ma, md, logic [3:0] mdw, miw, int cnt,
                             logic [3:0] fm, logic [31:0] fd);
    vec_t r;
    r.sv = sv; r.a = a; r.d = d; r.dw = dw; r.iw = iw; r.mr = mr; r.ld = ld;
    r.e_rdy = rdy; r.e_mv = mv; r.e_ma = ma; r.e_md = md; r.e_mdw = mdw; r.e_miw = miw;
    r.e_cnt = cnt; r.e_fm = fm; r.e_fd = fd;
    return r;
  endfunction

  typedef struct { logic [31:0] a, d; logic [3:0] dw, iw; } st_t;
  st_t q[$];

  task automatic model_check(input string tag);
    logic [3:0]  fm = 0;
    logic [31:0] fd = 0;
    foreach (q[k])
      if (q[k].a[31:2] == ld_addr_i[31:2])
        for (int l = 0; l < 4; l++)
          if (q[k].dw[l]) begin
            fm[l] = 1'b1;
            fd[8*l +: 8] = q[k].d[8*l +: 8];
          end
    chk({tag, "_rdy"}, 32'(st_ready_o), 32'(q.size() < DEPTH));
    chk({tag, "_mv"}, 32'(mem_valid_o), 32'(q.size() > 0));
    chk({tag, "_cnt"}, 32'(count_o), 32'(q.size()));
    chk({tag, "_empty"}, 32'(empty_o), 32'(q.size() == 0));
    chk({tag, "_fm"}, 32'(fwd_mask_o), 32'(fm));
    chk({tag, "_fd"}, fwd_data_o, fd);
    if (q.size() > 0) begin
      chk({tag, "_ma"}, mem_addr_o, q[0].a);
      chk({tag, "_md"}, mem_din_o, q[0].d);
      chk({tag, "_mdw"}, 32'(mem_dmem_wea_o), 32'(q[0].dw));
      chk({tag, "_miw"}, 32'(mem_imem_wea_o), 32'(q[0].iw));
    end else begin
      chk({tag, "_mdw"}, 32'(mem_dmem_wea_o), 0);
      chk({tag, "_miw"}, 32'(mem_imem_wea_o), 0);
    end
  endtask

  task automatic model_step();
    bit do_enq = st_valid_i && q.size() < DEPTH && (st_dmem_wea_i != 0 || st_imem_wea_i != 0);
    bit do_deq = q.size() > 0 && mem_ready_i;
    st_t s;
    s.a = st_addr_i; s.d = st_data_i; s.dw = st_dmem_wea_i; s.iw = st_imem_wea_i;
    if (do_deq) void'(q.pop_front());
    if (do_enq) q.push_back(s);
  endtask

  initial begin
    // basic SW, drain, hold-last-value
    tbl.push_back(v(1, 32'h10000004, 32'hDEADBEEF, 4'hF, 0, 1, 32'h10000004, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h10000004, 1, 1, 32'h10000004, 32'hDEADBEEF, 4'hF, 0, 1, 4'hF, 32'hDEADBEEF));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h10000004, 1, 0, 32'h10000004, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    // fill to full with memory stalled, then drain in order
    tbl.push_back(v(1, 32'h100, 32'h11111111, 4'hF, 0, 0, 0, 1, 0, 32'h10000004, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 32'h104, 32'h22222222, 4'hF, 0, 0, 0, 1, 1, 32'h100, 32'h11111111, 4'hF, 0, 1, 0, 0));
    tbl.push_back(v(1, 32'h108, 32'h33333333, 4'hF, 0, 0, 0, 1, 1, 32'h100, 32'h11111111, 4'hF, 0, 2, 0, 0));
    tbl.push_back(v(1, 32'h10C, 32'h44444444, 4'hF, 0, 0, 0, 1, 1, 32'h100, 32'h11111111, 4'hF, 0, 3, 0, 0));
    tbl.push_back(v(1, 32'h110, 32'h55555555, 4'hF, 0, 0, 0, 0, 1, 32'h100, 32'h11111111, 4'hF, 0, 4, 0, 0));
    tbl.push_back(v(1, 32'h110, 32'h55555555, 4'hF, 0, 1, 0, 0, 1, 32'h100, 32'h11111111, 4'hF, 0, 4, 0, 0));
    tbl.push_back(v(1, 32'h110, 32'h55555555, 4'hF, 0, 1, 0, 1, 1, 32'h104, 32'h22222222, 4'hF, 0, 3, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h108, 32'h33333333, 4'hF, 0, 3, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h10C, 32'h44444444, 4'hF, 0, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h110, 32'h55555555, 4'hF, 0, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h110, 32'h55555555, 0, 0, 0, 0, 0));
    // two SBs to the same byte: youngest wins
    tbl.push_back(v(1, 32'h10000001, 32'h0000AB00, 4'h2, 0, 0, 32'h10000000, 1, 0, 32'h110, 32'h55555555, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 32'h10000001, 32'h0000CD00, 4'h2, 0, 0, 32'h10000000, 1, 1, 32'h10000001, 32'h0000AB00, 4'h2, 0, 1, 4'h2, 32'h0000AB00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h10000000, 1, 1, 32'h10000001, 32'h0000AB00, 4'h2, 0, 2, 4'h2, 32'h0000CD00));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h10000000, 1, 1, 32'h10000001, 32'h0000AB00, 4'h2, 0, 2, 4'h2, 32'h0000CD00));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h10000000, 1, 1, 32'h10000001, 32'h0000CD00, 4'h2, 0, 1, 4'h2, 32'h0000CD00));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h10000000, 1, 0, 32'h10000001, 32'h0000CD00, 0, 0, 0, 0, 0));
    // two SHs merge lanes in the forwarded word
    tbl.push_back(v(1, 32'h10000000, 32'h00001234, 4'h3, 0, 0, 32'h10000000, 1, 0, 32'h10000001, 32'h0000CD00, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 32'h10000002, 32'h56780000, 4'hC, 0, 0, 32'h10000000, 1, 1, 32'h10000000, 32'h00001234, 4'h3, 0, 1, 4'h3, 32'h00001234));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h10000000, 1, 1, 32'h10000000, 32'h00001234, 4'h3, 0, 2, 4'hF, 32'h56781234));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h10000004, 1, 1, 32'h10000000, 32'h00001234, 4'h3, 0, 2, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h10000000, 1, 1, 32'h10000000, 32'h00001234, 4'h3, 0, 2, 4'hF, 32'h56781234));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h10000000, 1, 1, 32'h10000002, 32'h56780000, 4'hC, 0, 1, 4'hC, 32'h56780000));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h10000000, 1, 0, 32'h10000002, 32'h56780000, 0, 0, 0, 0, 0));
    // IMEM-only store never forwards; all-zero enables are dropped
    tbl.push_back(v(1, 32'h20000000, 32'hCAFEF00D, 0, 4'hF, 0, 32'h20000000, 1, 0, 32'h10000002, 32'h56780000, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h20000000, 1, 1, 32'h20000000, 32'hCAFEF00D, 0, 4'hF, 1, 0, 0));
    tbl.push_back(v(1, 32'h30000000, 32'h00000001, 0, 0, 0, 32'h20000000, 1, 1, 32'h20000000, 32'hCAFEF00D, 0, 4'hF, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 32'h20000000, 1, 1, 32'h20000000, 32'hCAFEF00D, 0, 4'hF, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 32'h20000000, 1, 0, 32'h20000000, 32'hCAFEF00D, 0, 0, 0, 0, 0));

    #3;
    chk("rst_rdy", 32'(st_ready_o), 1);
    chk("rst_mv", 32'(mem_valid_o), 0);
    chk("rst_cnt", 32'(count_o), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_ma", mem_addr_o, 0);
    chk("rst_md", mem_din_o, 0);
    chk("rst_fm", 32'(fwd_mask_o), 0);
    #9 rst_n = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      st_valid_i = tbl[i].sv; st_addr_i = tbl[i].a; st_data_i = tbl[i].d;
      st_dmem_wea_i = tbl[i].dw; st_imem_wea_i = tbl[i].iw;
      mem_ready_i = tbl[i].mr; ld_addr_i = tbl[i].ld;
      @(negedge clk);
      chk($sformatf("r%0d_rdy", i), 32'(st_ready_o), 32'(tbl[i].e_rdy));
      chk($sformatf("r%0d_mv", i), 32'(mem_valid_o), 32'(tbl[i].e_mv));
      chk($sformatf("r%0d_ma", i), mem_addr_o, tbl[i].e_ma);
      chk($sformatf("r%0d_md", i), mem_din_o, tbl[i].e_md);
      chk($sformatf("r%0d_mdw", i), 32'(mem_dmem_wea_o), 32'(tbl[i].e_mdw));
      chk($sformatf("r%0d_miw", i), 32'(mem_imem_wea_o), 32'(tbl[i].e_miw));
      chk($sformatf("r%0d_cnt", i), 32'(count_o), 32'(tbl[i].e_cnt));
      chk($sformatf("r%0d_empty", i), 32'(empty_o), 32'(tbl[i].e_cnt == 0));
      chk($sformatf("r%0d_fm", i), 32'(fwd_mask_o), 32'(tbl[i].e_fm));
      chk($sformatf("r%0d_fd", i), fwd_data_o, tbl[i].e_fd);
      @(posedge clk); #1;
    end

    // async reset in the middle of a cycle discards pending stores at once
    mem_ready_i = 0; ld_addr_i = 32'h10000000;
    for (int i = 0; i < 3; i++) begin
      st_valid_i = 1; st_addr_i = 32'h10000000 + 32'(4 * i); st_data_i = 32'hA5A50000 + 32'(i);
      st_dmem_wea_i = 4'hF; st_imem_wea_i = 0;
      @(posedge clk); #1;
    end
    st_valid_i = 0;
    #2 chk("arst_pre_cnt", 32'(count_o), 3);
    chk("arst_pre_fm", 32'(fwd_mask_o), 4'hF);
    rst_n = 0;
    #1;
    chk("arst_cnt", 32'(count_o), 0);
    chk("arst_mv", 32'(mem_valid_o), 0);
    chk("arst_fm", 32'(fwd_mask_o), 0);
    chk("arst_rdy", 32'(st_ready_o), 1);
    chk("arst_empty", 32'(empty_o), 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("arst_post_cnt", 32'(count_o), 0);
    q.delete();

    for (int c = 0; c < 3000; c++) begin
      st_valid_i    = $urandom_range(0, 3) != 0;
      st_addr_i     = 32'h10000000 | 32'($urandom_range(0, 3) << 2) | 32'($urandom_range(0, 3));
      st_data_i     = $urandom;
      st_dmem_wea_i = $urandom_range(0, 3) == 0 ? 4'h0 : 4'($urandom);
      st_imem_wea_i = $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'h0;
      mem_ready_i   = $urandom_range(0, 99) < ((c & 256) != 0 ? 75 : 30);
      ld_addr_i     = 32'h10000000 | 32'($urandom_range(0, 4) << 2);
      @(negedge clk);
      model_check("rnd");
      @(posedge clk);
      model_step();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
